// File: rtl/register_file_scoreboard.sv
// Register file with a per-register write-reservation scoreboard.
// Reservations carry a producer tag; only the latest producer of a register
// may commit to it. Reads are combinational with a bypass from the write-back
// ports. Flush drops every outstanding reservation.
module register_file_scoreboard #(
    parameter int OPERAND_WIDTH = 32,
    parameter int REG_COUNT     = 16,
    parameter int READ_PORTS    = 2,
    parameter int WB_PORTS      = 2,
    parameter int TAG_WIDTH     = 4,
    localparam int IDX_W        = $clog2(REG_COUNT)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rsv_valid,
    input  logic [IDX_W-1:0]                    rsv_index,
    input  logic [TAG_WIDTH-1:0]                rsv_tag,
    input  logic [READ_PORTS*IDX_W-1:0]         rd_index,
    output logic [READ_PORTS*OPERAND_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]               rd_ready,
    output logic [READ_PORTS*TAG_WIDTH-1:0]     rd_tag,
    input  logic [WB_PORTS-1:0]                 wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]           wb_index,
    input  logic [WB_PORTS*TAG_WIDTH-1:0]       wb_tag,
    input  logic [WB_PORTS*OPERAND_WIDTH-1:0]   wb_data,
    input  logic                                flush,
    output logic [REG_COUNT-1:0]                reserved_mask
);

    logic [OPERAND_WIDTH-1:0] data_q [REG_COUNT];
    logic [OPERAND_WIDTH-1:0] data_d [REG_COUNT];
    logic [TAG_WIDTH-1:0]     tag_q  [REG_COUNT];
    logic [TAG_WIDTH-1:0]     tag_d  [REG_COUNT];
    logic [REG_COUNT-1:0]     rsv_q;
    logic [REG_COUNT-1:0]     rsv_d;

    logic [IDX_W-1:0]         wb_idx_s  [WB_PORTS];
    logic [TAG_WIDTH-1:0]     wb_tag_s  [WB_PORTS];
    logic [OPERAND_WIDTH-1:0] wb_data_s [WB_PORTS];
    logic [WB_PORTS-1:0]      wb_match_s;
    logic [IDX_W-1:0]         rd_idx_s  [READ_PORTS];

    // Unpack write-back buses and decide which ports hold the live reservation
    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_idx_s[p]   = wb_index[p*IDX_W +: IDX_W];
            wb_tag_s[p]   = wb_tag[p*TAG_WIDTH +: TAG_WIDTH];
            wb_data_s[p]  = wb_data[p*OPERAND_WIDTH +: OPERAND_WIDTH];
            wb_match_s[p] = wb_valid[p]
                          && (wb_idx_s[p] != '0)
                          && rsv_q[wb_idx_s[p]]
                          && (tag_q[wb_idx_s[p]] == wb_tag_s[p]);
        end
    end

    // Next-state: commits first (highest port last wins), then reserve, then flush
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        rsv_d  = rsv_q;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_match_s[p]) begin
                data_d[wb_idx_s[p]] = wb_data_s[p];
                rsv_d[wb_idx_s[p]]  = 1'b0;
            end else begin
                data_d[wb_idx_s[p]] = data_d[wb_idx_s[p]];
            end
        end
        if (rsv_valid && (rsv_index != '0) && !flush) begin
            rsv_d[rsv_index] = 1'b1;
            tag_d[rsv_index] = rsv_tag;
        end else begin
            rsv_d = rsv_d;
        end
        if (flush) begin
            rsv_d = '0;
        end else begin
            rsv_d = rsv_d;
        end
    end

    // Architectural state; async reset wipes data, tags and reservations
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            rsv_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            rsv_q  <= rsv_d;
        end
    end

    // Read ports: r0 constant, then write-back bypass, then array contents
    always_comb begin
        rd_data  = '0;
        rd_ready = '0;
        rd_tag   = '0;
        for (int r = 0; r < READ_PORTS; r++) begin
            rd_idx_s[r] = rd_index[r*IDX_W +: IDX_W];
            rd_data[r*OPERAND_WIDTH +: OPERAND_WIDTH] = data_q[rd_idx_s[r]];
            rd_ready[r]                               = ~rsv_q[rd_idx_s[r]];
            rd_tag[r*TAG_WIDTH +: TAG_WIDTH]          = tag_q[rd_idx_s[r]];
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_match_s[p] && (wb_idx_s[p] == rd_idx_s[r])) begin
                    rd_data[r*OPERAND_WIDTH +: OPERAND_WIDTH] = wb_data_s[p];
                    rd_ready[r]                               = 1'b1;
                end else begin
                    rd_ready[r] = rd_ready[r];
                end
            end
            if (rd_idx_s[r] == '0) begin
                rd_data[r*OPERAND_WIDTH +: OPERAND_WIDTH] = '0;
                rd_ready[r]                               = 1'b1;
                rd_tag[r*TAG_WIDTH +: TAG_WIDTH]          = '0;
            end else begin
                rd_ready[r] = rd_ready[r];
            end
        end
    end

    assign reserved_mask = rsv_q;

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Parametrised register file with an integrated per-register write-reservation scoreboard, sitting between decode/issue and the write-back stage of the core. It provides multiple combinational read ports with ready status and same-cycle write-back bypass, and multiple write-back ports. It tags each reservation, so only the most recent producer of a register may commit to it or release it. A flush input drops all outstanding reservations after a squash.

## Interface
Parameters:
- OPERAND_WIDTH, from register_file_params: data width of every register.
- REG_COUNT, 16: number of architectural registers. Must be a power of two, ≥ 2.
- READ_PORTS, 2: number of combinational read ports.
- WB_PORTS, 2: number of write-back ports.
- TAG_WIDTH, 4: width of the producer tag.
- IDX_W, $clog2(REG_COUNT): derived register index width. Not overridable.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock; all state changes on its rising edge.
  - rst  in  1  asynchronous, active-low reset.
- Reservation port:
  - rsv_valid  in  1  reserve register rsv_index for producer rsv_tag.
  - rsv_index  in  IDX_W  register to reserve.
  - rsv_tag  in  TAG_WIDTH  producer tag.
- Read ports:
  - rd_index  in  READ_PORTS×IDX_W  read addresses.
  - rd_data  out  READ_PORTS×OPERAND_WIDTH  read data, combinational.
  - rd_ready  out  READ_PORTS  1 = rd_data is final (no pending producer).
  - rd_tag  out  READ_PORTS×TAG_WIDTH  pending producer tag. Meaningful only when rd_ready=0.
- Write-back ports:
  - wb_valid  in  WB_PORTS  write-back request per port.
  - wb_index  in  WB_PORTS×IDX_W  destination register.
  - wb_tag  in  WB_PORTS×TAG_WIDTH  producer tag.
  - wb_data  in  WB_PORTS×OPERAND_WIDTH  result.
- Control and status:
  - flush  in  1  clear all reservation bits.
  - reserved_mask  out  REG_COUNT  registered reservation bits, bit i = register i.

## Operation
Per-register state: data[OPERAND_WIDTH], rsv bit, tag[TAG_WIDTH].

Register 0:
- Hardwired to zero.
- Reads of register 0 return 0 with ready=1.
- Reserve and write-back to register 0 are ignored.

Reserve:
- Next edge: rsv←1, tag←rsv_tag.
- Reserving an already-reserved register is legal. The new tag replaces the old one; this orphans the older producer.

Write-back port p matches when all of the following hold:
- wb_valid[p]=1
- wb_index[p]≠0
- rsv[wb_index[p]]=1
- tag[wb_index[p]]=wb_tag[p]

On a matching write-back, the next edge does data←wb_data[p] and rsv←0.

Non-matching write-backs are discarded entirely, with no data write. This covers stale tags and unreserved destinations, and prevents WAW clobbering.

Two matching ports on the same register in one cycle: the highest port index wins. This is a protocol error but must be deterministic.

Read port r, with i = rd_index[r], resolved in this priority order:
- If i=0: data 0, ready=1.
- Else, if a write-back port matches register i in this cycle: data = that port's wb_data (highest matching port), ready=1. This is the bypass.
- Else: data[i], ready = ~rsv[i], rd_tag = tag[i].

Reads never observe a same-cycle reservation. The reservation becomes visible from the next cycle.

Simultaneous events on the same register in one cycle:
- Reserve and matching write-back: the data write happens. rsv ends at 1 and tag ends at rsv_tag, so the new reservation wins.
- Flush: every rsv bit ends at 0 and the reservation request in that cycle is ignored.
- Matching write-backs in a flush cycle still write data. Matching is evaluated against the pre-flush state.
- Flush does not alter data or tag fields.

reserved_mask reflects the registered rsv bits only. It has no bypass.

## Timing
- Reset: every data, rsv and tag field clears to 0 immediately on rst low, independent of clk.
  - reserved_mask = 0.
  - All rd_ready = 1.
  - rd_data = 0 and rd_tag = 0 for every index.
- Reset mid-operation discards all reservations and data. Write-backs presented during reset are lost.
- Read path is combinational: 0-cycle latency from rd_index/wb_* to rd_data/rd_ready.
- A write-back committed at edge N is readable from the array from cycle N onward. In cycle N−1 it is visible only through bypass.
- A reservation presented in cycle N−1 is visible on reserved_mask and rd_ready from cycle N.
- No stall or backpressure outputs: all requests are accepted in the cycle they are presented.

## Test plan
- Reset with wb_valid held high on all ports: everything zero, reserved_mask=0, all rd_ready=1. After rst release, the stale writes are ignored because no register is reserved.
- Reserve r5 with tag 3, then the next cycle read r5: ready=0, rd_tag=3. Write back r5 with tag 3 and data 0xA5A5_0001: the same-cycle read shows ready=1 and that data via bypass, and the next cycle shows it from the array with reserved_mask[5]=0.
- WAW: reserve r7 with tag 1, then r7 with tag 2. A write-back of r7 with tag 1 and data 0x11 is dropped (r7 still reserved, data unchanged). A write-back of r7 with tag 2 and data 0x22 then commits 0x22.
- In one cycle, reserve r3 with tag 6 and write back r3 with tag 4 (matching the prior reservation) and data 0x33 → data=0x33, rsv=1, tag=6.
- Flush with r2/r4/r9 reserved, plus a reserve of r10 and a matching write-back of r4 with data 0x44 in the same cycle → reserved_mask=0, r10 not reserved, r4 data=0x44.
- Two ports write back to the same matching register in one cycle with data 0xAA (port 0) and 0xBB (port 1) → bypass and committed data are both 0xBB. Writes and reserves to r0 leave r0 reading 0 with ready=1.
